// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: receiver FSM states and parity-mode encodings shared by the receiver files
package uart_rx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line in plus host-side word/interrupt/acknowledge signals
interface uart_rx_param_if #(parameter int DATA_BITS = 8, parameter int FIFO_DEPTH = 4);
  logic dataIn;
  logic host_aknowledged;
  logic err_clear;
  logic [DATA_BITS-1:0] dataOut;
  logic [2:0] err;
  logic host_interrupt;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  modport master(output dataIn, host_aknowledged, err_clear,
                 input dataOut, err, host_interrupt, fifo_count);
  modport slave(input dataIn, host_aknowledged, err_clear,
                output dataOut, err, host_interrupt, fifo_count);
endinterface

// File: rtl/uart_rx_param_rx_fifo.sv
// rx_fifo: first-word fall-through FIFO; head reads as zero while empty
module rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_pop, do_push;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  // a full FIFO still accepts a word when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign rdata = empty ? '0 : mem[rptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= wdata;
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled serial receiver with synchroniser, parity/framing checks and word FIFO
module uart_rx_param import uart_rx_pkg::*; #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 1,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic             overSampler,
  input logic             reset,
  uart_rx_param_if.slave  bus
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  state_t state;
  logic s1, rxs;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;
  logic sbit;
  logic [DATA_BITS-1:0] shreg;
  logic perr, ferr, ovr, tick, last_stop, full, empty;
  logic [DATA_BITS+1:0] head;
  assign tick = cnt == CW'(OVERSAMPLE-1);
  assign last_stop = state == ST_STOP && tick && sbit == 1'(STOP_BITS-1);
  rx_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(overSampler),
    .rst(reset),
    .push(last_stop),
    .pop(bus.host_aknowledged),
    .wdata({perr, ferr | ~rxs, shreg}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(bus.fifo_count)
  );
  assign bus.dataOut = head[DATA_BITS-1:0];
  assign bus.err = {head[DATA_BITS+1:DATA_BITS], ovr};
  assign bus.host_interrupt = !empty;
  always_ff @(posedge overSampler or posedge reset)
    if (reset) {s1, rxs} <= 2'b11;
    else {s1, rxs} <= {bus.dataIn, s1};
  // an overrun in the same cycle as a clear must survive it
  always_ff @(posedge overSampler or posedge reset)
    if (reset) ovr <= 1'b0;
    else ovr <= (last_stop && full && !bus.host_aknowledged) ? 1'b1 : bus.err_clear ? 1'b0 : ovr;
  always_ff @(posedge overSampler or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      cnt <= '0;
      bcnt <= '0;
      sbit <= 1'b0;
      shreg <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rxs) begin
            state <= ST_START;
            perr <= 1'b0;
            ferr <= 1'b0;
          end
        end
        ST_START:
          if (cnt == CW'(OVERSAMPLE/2-1)) begin
            cnt <= '0;
            state <= rxs ? ST_IDLE : ST_DATA;
          end
        ST_DATA:
          if (tick) begin
            shreg <= {rxs, shreg[DATA_BITS-1:1]};
            bcnt <= bcnt + 1'b1;
            if (bcnt == BW'(DATA_BITS-1)) begin
              bcnt <= '0;
              state <= PARITY == PAR_NONE ? ST_STOP : ST_PARITY;
            end
          end
        ST_PARITY:
          if (tick) begin
            perr <= (^shreg ^ rxs) != (PARITY == PAR_ODD);
            state <= ST_STOP;
          end
        ST_STOP:
          if (tick) begin
            if (!rxs) ferr <= 1'b1;
            sbit <= last_stop ? 1'b0 : 1'b1;
            if (last_stop) state <= ST_IDLE;
          end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed frames against an 8E1 receiver (queue model) and a 7N2 receiver
module tb_uart_rx_param;
  localparam int PUSH_A = 170;
  logic overSampler = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [9:0] mq[$];
  logic movr = 1'b0;
  always #5 overSampler = ~overSampler;
  uart_rx_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) a_if();
  uart_rx_param_if #(.DATA_BITS(7), .FIFO_DEPTH(4)) b_if();
  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.overSampler(overSampler), .reset(reset), .bus(a_if));
  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_b (.overSampler(overSampler), .reset(reset), .bus(b_if));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [14:0] model_out();
    logic [9:0] h = mq.size() > 0 ? mq[0] : 10'h0;
    return {h[7:0], h[9:8], movr, mq.size() > 0, 3'(mq.size())};
  endfunction
  always @(negedge overSampler)
    if (chk_en)
      check("model", {a_if.dataOut, a_if.err, a_if.host_interrupt, a_if.fifo_count}, model_out());
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge overSampler);
      #1;
    end
  endtask
  // frame = start, 8 data LSB first, even parity (optionally inverted), one stop bit
  task automatic send_a(input logic [7:0] d, input bit bad_par, input bit stop,
                        input int ack_at = -1, input int clr_at = -1);
    logic [10:0] bits;
    int c = 0;
    bit ovr_now;
    bits = {stop, ^d ^ bad_par, d, 1'b0};
    chk_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      a_if.dataIn = bits[i];
      repeat (16) begin
        @(posedge overSampler);
        #1;
        c++;
        a_if.host_aknowledged = c == ack_at;
        a_if.err_clear = c == clr_at;
      end
    end
    a_if.dataIn = 1'b1;
    if (ack_at >= 0 && mq.size() > 0) void'(mq.pop_front());
    ovr_now = mq.size() == 4;
    if (!ovr_now) mq.push_back({^bits[9:1], ~stop, d});
    movr = ovr_now ? 1'b1 : (clr_at >= 0 ? 1'b0 : movr);
    tick(4);
    chk_en = 1'b1;
  endtask
  task automatic ack_a();
    a_if.host_aknowledged = 1'b1;
    tick(1);
    a_if.host_aknowledged = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask
  task automatic clr_a();
    a_if.err_clear = 1'b1;
    tick(1);
    a_if.err_clear = 1'b0;
    movr = 1'b0;
  endtask
  task automatic send_b(input logic [6:0] d, input bit st1, input bit st2);
    logic [9:0] bits;
    bits = {st2, st1, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      b_if.dataIn = bits[i];
      tick(16);
    end
    b_if.dataIn = 1'b1;
    tick(4);
  endtask
  task automatic ack_b();
    b_if.host_aknowledged = 1'b1;
    tick(1);
    b_if.host_aknowledged = 1'b0;
  endtask
  initial begin
    logic [7:0] drain [4] = '{8'h02, 8'h03, 8'h04, 8'h06};
    a_if.dataIn = 1'b1;
    a_if.host_aknowledged = 1'b0;
    a_if.err_clear = 1'b0;
    b_if.dataIn = 1'b1;
    b_if.host_aknowledged = 1'b0;
    b_if.err_clear = 1'b0;
    tick(3);
    check("reset_outputs", {a_if.dataOut, a_if.err, a_if.host_interrupt, a_if.fifo_count}, 0);
    reset = 1'b0;
    tick(2);
    chk_en = 1'b1;
    send_a(8'hA5, 0, 1);
    check("a5_data", a_if.dataOut, 8'hA5);
    check("a5_err", a_if.err, 3'b000);
    check("a5_irq", a_if.host_interrupt, 1);
    ack_a();
    check("a5_ack_irq", a_if.host_interrupt, 0);
    check("a5_ack_count", a_if.fifo_count, 0);
    a_if.dataIn = 1'b0;
    tick(5);
    a_if.dataIn = 1'b1;
    tick(30);
    check("false_start_count", a_if.fifo_count, 0);
    send_a(8'h3C, 1, 1);
    check("par_data", a_if.dataOut, 8'h3C);
    check("par_err2", a_if.err[2], 1);
    send_a(8'h81, 0, 1);
    ack_a();
    check("clean_data", a_if.dataOut, 8'h81);
    check("clean_err", a_if.err, 3'b000);
    ack_a();
    send_a(8'h42, 0, 1, PUSH_A);
    check("push_pop_empty_count", a_if.fifo_count, 1);
    check("push_pop_empty_data", a_if.dataOut, 8'h42);
    ack_a();
    send_a(8'h0F, 0, 0);
    check("frame_data", a_if.dataOut, 8'h0F);
    check("frame_err", a_if.err, 3'b010);
    ack_a();
    send_a(8'h00, 0, 0);
    check("break_data", a_if.dataOut, 8'h00);
    check("break_err", a_if.err, 3'b010);
    check("break_count", a_if.fifo_count, 1);
    ack_a();
    for (int k = 1; k <= 5; k++) send_a(8'(k), 0, 1);
    check("ovr_count", a_if.fifo_count, 4);
    check("ovr_flag", a_if.err[0], 1);
    check("ovr_head", a_if.dataOut, 8'h01);
    send_a(8'h06, 0, 1, PUSH_A, PUSH_A);
    check("full_push_pop_count", a_if.fifo_count, 4);
    check("full_push_pop_ovr", a_if.err[0], 0);
    send_a(8'h07, 0, 1, -1, PUSH_A);
    check("clr_vs_ovr", a_if.err[0], 1);
    for (int k = 0; k < 4; k++) begin
      check("drain_order", a_if.dataOut, drain[k]);
      ack_a();
    end
    check("empty_err", a_if.err, 3'b001);
    clr_a();
    check("cleared_err", a_if.err, 3'b000);
    send_a(8'h77, 0, 1);
    chk_en = 1'b0;
    a_if.dataIn = 1'b0;
    tick(16);
    for (int i = 0; i < 3; i++) begin
      a_if.dataIn = i == 1;
      tick(16);
    end
    reset = 1'b1;
    a_if.dataIn = 1'b1;
    tick(2);
    check("midframe_reset", {a_if.dataOut, a_if.err, a_if.host_interrupt, a_if.fifo_count}, 0);
    mq.delete();
    movr = 1'b0;
    reset = 1'b0;
    tick(3);
    chk_en = 1'b1;
    send_a(8'h5A, 0, 1);
    check("after_reset_data", a_if.dataOut, 8'h5A);
    check("after_reset_err", a_if.err, 3'b000);
    ack_a();
    send_b(7'h55, 1, 1);
    check("b_good_data", b_if.dataOut, 7'h55);
    check("b_good_err", b_if.err, 3'b000);
    check("b_good_count", b_if.fifo_count, 1);
    ack_b();
    check("b_empty_data", b_if.dataOut, 7'h00);
    send_b(7'h2A, 1, 0);
    check("b_stop2_data", b_if.dataOut, 7'h2A);
    check("b_stop2_err", b_if.err, 3'b010);
    ack_b();
    send_b(7'h11, 0, 1);
    check("b_stop1_err", b_if.err, 3'b010);
    ack_b();
    send_b(7'h7F, 1, 1);
    check("b_7f_data", b_if.dataOut, 7'h7F);
    check("b_7f_err", b_if.err, 3'b000);
    ack_b();
    check("b_final_count", b_if.fifo_count, 0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
